// File: rtl/sd_data_control_multi_pkg.sv
// Shared definitions for the multi-block SD DATA-path controller:
// FSM state encoding and the legal SD DAT lane counts.
package sd_data_pkg;

  typedef enum logic [2:0] {
    ST_IDLE            = 3'd0,
    ST_SETTING_OUTPUTS = 3'd1,
    ST_CHECK_FIFO      = 3'd2,
    ST_TRANSMIT        = 3'd3,
    ST_ACK             = 3'd4,
    ST_DONE            = 3'd5,
    ST_ERROR           = 3'd6
  } data_state_t;

  localparam int unsigned BUS_W_1 = 1;
  localparam int unsigned BUS_W_4 = 4;

  // The Phy only supports 1-lane and 4-lane DAT operation.
  function automatic logic bus_w_legal(input int unsigned w);
    return (w == BUS_W_1) || (w == BUS_W_4);
  endfunction

endpackage

// File: rtl/sd_data_control_multi_if.sv
// Handshake and configuration bundle between the DATA controller (master)
// and the SD physical layer (slave).
interface sd_data_control_multi_if #(
  parameter int BC_W = 4,
  parameter int TO_W = 16
);
  logic            serial_Ready_Phy_DATA;
  logic            timeout_Phy_DATA;
  logic            complete_Phy_DATA;
  logic            ack_IN_Phy_DATA;
  logic            strobe_OUT_DATA_Phy;
  logic            ack_OUT_DATA_Phy;
  logic            idle_OUT_DATA_Phy;
  logic [BC_W-1:0] blocks_DATA_Phy;
  logic [TO_W-1:0] timeout_Reg_DATA_Phy;
  logic            writeRead_DATA_Phy;
  logic            multiple_DATA_Phy;
  logic [2:0]      busWidth_DATA_Phy;

  modport master (
    input  serial_Ready_Phy_DATA, timeout_Phy_DATA, complete_Phy_DATA, ack_IN_Phy_DATA,
    output strobe_OUT_DATA_Phy, ack_OUT_DATA_Phy, idle_OUT_DATA_Phy, blocks_DATA_Phy,
           timeout_Reg_DATA_Phy, writeRead_DATA_Phy, multiple_DATA_Phy, busWidth_DATA_Phy
  );

  modport slave (
    output serial_Ready_Phy_DATA, timeout_Phy_DATA, complete_Phy_DATA, ack_IN_Phy_DATA,
    input  strobe_OUT_DATA_Phy, ack_OUT_DATA_Phy, idle_OUT_DATA_Phy, blocks_DATA_Phy,
           timeout_Reg_DATA_Phy, writeRead_DATA_Phy, multiple_DATA_Phy, busWidth_DATA_Phy
  );
endinterface

// File: rtl/sd_data_control_multi_timeout_cnt.sv
// Watchdog for the DATA controller. Down-counter reloaded with the limit on
// clear; expires when it reaches zero, i.e. after 'limit' enabled cycles
// following the clear. A limit of zero never expires.
module sd_data_timeout_cnt #(
  parameter int TO_W = 16
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_clr,
  input  logic            i_en,
  input  logic [TO_W-1:0] i_limit,
  output logic            o_expired
);

  logic [TO_W-1:0] r_count;

  // Reload on clear, otherwise count down while enabled, stopping at zero.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= i_limit;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - TO_W'(1);
    end
  end

  assign o_expired = i_en && (i_limit != '0) && (r_count == '0);

endmodule

// File: rtl/sd_data_control_multi.sv
// Multi-block SD DATA-path controller: sequences read/write block transfers
// between DMA, FIFO and the Phy with a per-block index, a watchdog and a
// configurable DAT bus width.
// Build option: define DATA_RETRY_EN to let a Phy timeout during TRANSMIT
// resend the same block up to MAX_RETRY times instead of raising an error.
//
// state           | meaning
// IDLE            | waiting for a DMA request, Phy held idle
// SETTING_OUTPUTS | configuration latched, waiting for Phy ready
// CHECK_FIFO      | waiting for FIFO data/room for the next block
// TRANSMIT        | block on the wire, FIFO port enabled
// ACK             | ack_OUT raised, waiting for Phy acknowledge
// DONE            | all blocks done, waiting for DMA request to drop
// ERROR           | timeout seen, waiting for DMA request to drop
module sd_data_control_multi
  import sd_data_pkg::*;
#(
  parameter int BC_W      = 4,
  parameter int TO_W      = 16,
  parameter int BUS_W     = 1,
  parameter int MAX_RETRY = 2
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_writeRead_Regs_DATA,
  input  logic [BC_W-1:0] i_blockCount_Regs_DATA,
  input  logic            i_multipleData_Regs_DATA,
  input  logic            i_timeout_Enable_Regs_DATA,
  input  logic [TO_W-1:0] i_timeout_Reg_Regs_DATA,
  input  logic            i_new_DAT_DMA_DATA,
  input  logic            i_fifo_OK_FIFO_DATA,
  sd_data_control_multi_if.master phy,
  output logic            o_writeFIFO_enable,
  output logic            o_readFIFO_enable,
  output logic [BC_W-1:0] o_block_Index_DATA,
  output logic            o_transfer_complete_DATA_DMA,
  output logic            o_timeout_Error_DATA_INT
);

  localparam int IDX_W   = BC_W + 1;
  localparam int RETRY_W = $clog2(MAX_RETRY + 1) + 1;
`ifdef DATA_RETRY_EN
  localparam int RETRY_LIMIT = MAX_RETRY;
`else
  localparam int RETRY_LIMIT = 0;
`endif

  data_state_t      r_state, w_next;
  logic [BC_W-1:0]  r_blocks;
  logic [TO_W-1:0]  r_to_limit;
  logic             r_to_en;
  logic             r_dir;
  logic             r_multi;
  logic [BC_W-1:0]  r_index;
  logic [RETRY_W-1:0] r_retry;
  logic             r_strobe;
  logic             r_done_pulse;
  logic             r_err;

  logic             w_start;
  logic             w_block_ack;
  logic             w_retry;
  logic             w_retry_ok;
  logic             w_last;
  logic             w_wd_active;
  logic             w_wd_clr;
  logic             w_expired;
  logic [IDX_W-1:0] w_idx_inc;
  logic [IDX_W-1:0] w_eff_count;

  // Index and count compared one bit wider so a full 2^BC_W-1 count never wraps.
  assign w_idx_inc   = {1'b0, r_index} + IDX_W'(1);
  assign w_eff_count = (r_blocks == '0) ? IDX_W'(1) : {1'b0, r_blocks};
  assign w_last      = !r_multi || (w_idx_inc >= w_eff_count);
  assign w_retry_ok  = (RETRY_LIMIT != 0) && (int'(r_retry) < RETRY_LIMIT);

  assign w_wd_active = (r_state == ST_CHECK_FIFO) || (r_state == ST_TRANSMIT) ||
                       (r_state == ST_ACK);
  assign w_wd_clr    = (w_next != r_state);

  sd_data_timeout_cnt #(.TO_W(TO_W)) u_timeout_cnt (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_clr     (w_wd_clr),
    .i_en      (r_to_en && w_wd_active),
    .i_limit   (r_to_limit),
    .o_expired (w_expired)
  );

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  // Next-state logic; forward progress beats a coincident timeout.
  always_comb begin
    w_next      = r_state;
    w_start     = 1'b0;
    w_block_ack = 1'b0;
    w_retry     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_new_DAT_DMA_DATA) begin
          w_next  = ST_SETTING_OUTPUTS;
          w_start = 1'b1;
        end
      end
      ST_SETTING_OUTPUTS: begin
        if (phy.serial_Ready_Phy_DATA) w_next = ST_CHECK_FIFO;
      end
      ST_CHECK_FIFO: begin
        if (i_fifo_OK_FIFO_DATA)                        w_next = ST_TRANSMIT;
        else if (w_expired || phy.timeout_Phy_DATA)     w_next = ST_ERROR;
      end
      ST_TRANSMIT: begin
        if (phy.complete_Phy_DATA) begin
          w_next = ST_ACK;
        end else if (phy.timeout_Phy_DATA && w_retry_ok) begin
          w_next  = ST_CHECK_FIFO;
          w_retry = 1'b1;
        end else if (phy.timeout_Phy_DATA || w_expired) begin
          w_next = ST_ERROR;
        end
      end
      ST_ACK: begin
        if (phy.ack_IN_Phy_DATA) begin
          w_block_ack = 1'b1;
          w_next      = w_last ? ST_DONE : ST_CHECK_FIFO;
        end else if (w_expired || phy.timeout_Phy_DATA) begin
          w_next = ST_ERROR;
        end
      end
      ST_DONE, ST_ERROR: begin
        if (!i_new_DAT_DMA_DATA) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Configuration latch, block/retry counters, pulses and sticky error.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_blocks     <= '0;
      r_to_limit   <= '0;
      r_to_en      <= 1'b0;
      r_dir        <= 1'b0;
      r_multi      <= 1'b0;
      r_index      <= '0;
      r_retry      <= '0;
      r_strobe     <= 1'b0;
      r_done_pulse <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_strobe     <= (r_state == ST_CHECK_FIFO) && (w_next == ST_TRANSMIT);
      r_done_pulse <= (r_state != ST_DONE) && (w_next == ST_DONE);
      if (w_start) begin
        r_blocks   <= i_blockCount_Regs_DATA;
        r_to_limit <= i_timeout_Reg_Regs_DATA;
        r_to_en    <= i_timeout_Enable_Regs_DATA;
        r_dir      <= i_writeRead_Regs_DATA;
        r_multi    <= i_multipleData_Regs_DATA;
        r_index    <= '0;
        r_retry    <= '0;
        r_err      <= 1'b0;
      end
      if ((r_state != ST_ERROR) && (w_next == ST_ERROR)) r_err <= 1'b1;
      if (w_block_ack) begin
        r_index <= w_idx_inc[BC_W-1:0];
        r_retry <= '0;
      end else if (w_retry) begin
        r_retry <= r_retry + RETRY_W'(1);
      end
    end
  end

  assign phy.strobe_OUT_DATA_Phy  = r_strobe;
  assign phy.ack_OUT_DATA_Phy     = (r_state == ST_ACK);
  assign phy.idle_OUT_DATA_Phy    = (r_state == ST_IDLE) || (r_state == ST_DONE) ||
                                    (r_state == ST_ERROR);
  assign phy.blocks_DATA_Phy      = r_blocks;
  assign phy.timeout_Reg_DATA_Phy = r_to_limit;
  assign phy.writeRead_DATA_Phy   = r_dir;
  assign phy.multiple_DATA_Phy    = r_multi;
  assign phy.busWidth_DATA_Phy    = 3'(bus_w_legal(BUS_W) ? BUS_W : BUS_W_1);

  assign o_writeFIFO_enable           = (r_state == ST_TRANSMIT) && !r_dir;
  assign o_readFIFO_enable            = (r_state == ST_TRANSMIT) && r_dir;
  assign o_block_Index_DATA           = r_index;
  assign o_transfer_complete_DATA_DMA = r_done_pulse;
  assign o_timeout_Error_DATA_INT     = r_err;

endmodule

// File: tb/tb_sd_data_control_multi.sv
// Bench for sd_data_control_multi: a randomized Phy/FIFO responder drives
// whole transfers; expectations come from the transfer parameters alone.
module tb_sd_data_control_multi;

  localparam int BC_W      = 4;
  localparam int TO_W      = 16;
  localparam int BUS_W     = 1;
  localparam int MAX_RETRY = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            wr_rd, multi, to_en, new_dat, fifo_ok;
  logic [BC_W-1:0] blk_cnt;
  logic [TO_W-1:0] to_lim;
  logic            wfifo_en, rfifo_en, xfer_done, to_err;
  logic [BC_W-1:0] blk_idx;

  always #5 clk = ~clk;

  sd_data_control_multi_if #(.BC_W(BC_W), .TO_W(TO_W)) phy_if ();

  sd_data_control_multi #(.BC_W(BC_W), .TO_W(TO_W), .BUS_W(BUS_W), .MAX_RETRY(MAX_RETRY)) dut (
    .i_clk                        (clk),
    .i_reset                      (rst),
    .i_writeRead_Regs_DATA        (wr_rd),
    .i_blockCount_Regs_DATA       (blk_cnt),
    .i_multipleData_Regs_DATA     (multi),
    .i_timeout_Enable_Regs_DATA   (to_en),
    .i_timeout_Reg_Regs_DATA      (to_lim),
    .i_new_DAT_DMA_DATA           (new_dat),
    .i_fifo_OK_FIFO_DATA          (fifo_ok),
    .phy                          (phy_if.master),
    .o_writeFIFO_enable           (wfifo_en),
    .o_readFIFO_enable            (rfifo_en),
    .o_block_Index_DATA           (blk_idx),
    .o_transfer_complete_DATA_DMA (xfer_done),
    .o_timeout_Error_DATA_INT     (to_err)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] out_vec();
    return 64'({phy_if.strobe_OUT_DATA_Phy, phy_if.ack_OUT_DATA_Phy, phy_if.idle_OUT_DATA_Phy,
                phy_if.blocks_DATA_Phy, phy_if.timeout_Reg_DATA_Phy, phy_if.writeRead_DATA_Phy,
                phy_if.multiple_DATA_Phy, wfifo_en, rfifo_en, blk_idx, xfer_done, to_err});
  endfunction

  localparam logic [63:0] RESET_VEC = 64'({1'b0, 1'b0, 1'b1, 4'd0, 16'd0, 1'b0, 1'b0,
                                           1'b0, 1'b0, 4'd0, 1'b0, 1'b0});

  // Blocks a transfer should move, from the register settings alone.
  function automatic int exp_blocks(input logic [BC_W-1:0] cnt, input logic m);
    if (!m) return 1;
    return (cnt == 0) ? 1 : int'(cnt);
  endfunction

  int g_strobes, g_completes, g_busy;
  bit g_timed_out, g_dir_ok, g_reset_hit;

  // One transfer, entered and left on a negative edge. fifo_hold keeps the
  // FIFO not-ready for that many cycles; inj_blk gets a Phy timeout on its
  // first attempt; rst_blk asserts reset when that block strobes.
  task automatic run_xfer(input logic dir, input logic [BC_W-1:0] cnt, input logic m,
                          input logic ten, input logic [TO_W-1:0] lim, input int fifo_hold,
                          input int inj_blk, input bit always_ready, input int rst_blk);
    int cyc = 0, phase = 0, cd = 0, done_blk = 0;
    bit seen_busy = 0, injected = 0;
    g_strobes = 0; g_completes = 0; g_busy = 0;
    g_timed_out = 0; g_dir_ok = 1; g_reset_hit = 0;
    wr_rd = dir; blk_cnt = cnt; multi = m; to_en = ten; to_lim = lim;
    new_dat = 1'b1;
    phy_if.serial_Ready_Phy_DATA = always_ready ? 1'b1 : 1'($urandom_range(0, 1));
    fifo_ok = 1'b0;
    while (1) begin
      @(negedge clk);
      cyc++;
      if (cyc > 5000) begin g_timed_out = 1; break; end
      if (!phy_if.idle_OUT_DATA_Phy) begin seen_busy = 1; g_busy++; end
      if (xfer_done) g_completes++;
      phy_if.complete_Phy_DATA = 1'b0;
      phy_if.timeout_Phy_DATA  = 1'b0;
      phy_if.ack_IN_Phy_DATA   = 1'b0;
      phy_if.serial_Ready_Phy_DATA = always_ready ? 1'b1 : 1'($urandom_range(0, 1));
      fifo_ok = (cyc <= fifo_hold) ? 1'b0 : 1'($urandom_range(0, 1));
      if (phy_if.strobe_OUT_DATA_Phy) begin
        g_strobes++;
        if ((wfifo_en !== !dir) || (rfifo_en !== dir)) g_dir_ok = 0;
        if (rst_blk == done_blk) begin
          rst = 1'b1; new_dat = 1'b0; g_reset_hit = 1;
          break;
        end
        if ((inj_blk == done_blk) && !injected) begin
          injected = 1; phy_if.timeout_Phy_DATA = 1'b1; phase = 0;
        end else begin
          phase = 1; cd = $urandom_range(0, 4);
        end
      end
      if (phase == 1) begin
        if (cd == 0) begin phy_if.complete_Phy_DATA = 1'b1; phase = 2; end
        else cd--;
      end else if ((phase == 2) && phy_if.ack_OUT_DATA_Phy) begin
        cd = $urandom_range(0, 3); phase = 3;
      end
      if (phase == 3) begin
        if (cd == 0) begin phy_if.ack_IN_Phy_DATA = 1'b1; phase = 0; done_blk++; end
        else cd--;
      end
      if (seen_busy && phy_if.idle_OUT_DATA_Phy) break;
    end
    fifo_ok = 1'b0;
    phy_if.complete_Phy_DATA = 1'b0;
    phy_if.timeout_Phy_DATA  = 1'b0;
    phy_if.ack_IN_Phy_DATA   = 1'b0;
    if (!g_reset_hit) begin
      repeat (3) begin
        @(negedge clk);
        if (xfer_done) g_completes++;
      end
      new_dat = 1'b0;
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic check_xfer(input string tag, input int strobes, input int completes,
                            input int idx, input logic err);
    check_eq({tag, "_bound"},     64'(g_timed_out), 64'd0);
    check_eq({tag, "_strobes"},   64'(g_strobes), 64'(strobes));
    check_eq({tag, "_completes"}, 64'(g_completes), 64'(completes));
    check_eq({tag, "_index"},     64'(blk_idx), 64'(idx));
    check_eq({tag, "_error"},     64'(to_err), 64'(err));
    check_eq({tag, "_idle"},      64'(phy_if.idle_OUT_DATA_Phy), 64'd1);
  endtask

  initial begin
    int nb, lim_b;
    logic d, m, te;
    logic [BC_W-1:0] c;
    logic [TO_W-1:0] l;
    rst = 1'b1; wr_rd = 0; blk_cnt = '0; multi = 0; to_en = 0; to_lim = '0;
    new_dat = 0; fifo_ok = 0;
    phy_if.serial_Ready_Phy_DATA = 0; phy_if.timeout_Phy_DATA = 0;
    phy_if.complete_Phy_DATA = 0; phy_if.ack_IN_Phy_DATA = 0;
    repeat (3) @(negedge clk);
    check_eq("reset_vec", out_vec(), RESET_VEC);
    check_eq("bus_width", 64'(phy_if.busWidth_DATA_Phy), 64'(BUS_W));
    rst = 1'b0;
    @(negedge clk);

    run_xfer(1'b1, 4'd15, 1'b0, 1'b1, 16'd100, 5, -1, 0, -1);
    check_xfer("single_wr", 1, 1, 1, 1'b0);
    check_eq("single_wr_dir", 64'(g_dir_ok), 64'd1);

    run_xfer(1'b1, 4'd15, 1'b1, 1'b1, 16'd100, 0, -1, 0, -1);
    check_xfer("multi_wr15", 15, 1, 15, 1'b0);

    run_xfer(1'b0, 4'd3, 1'b1, 1'b1, 16'd100, 100000, -1, 1, -1);
    check_xfer("fifo_stall", 0, 0, 0, 1'b1);
    check_eq("fifo_stall_busy", 64'(g_busy), 64'd102);

    run_xfer(1'b0, 4'd0, 1'b1, 1'b0, 16'd0, 2, -1, 0, -1);
    check_xfer("count0", 1, 1, 1, 1'b0);
    check_eq("count0_dir", 64'(g_dir_ok), 64'd1);

    run_xfer(1'b1, 4'd4, 1'b1, 1'b1, 16'd200, 0, 1, 0, -1);
`ifdef DATA_RETRY_EN
    check_xfer("phy_to_blk2", 5, 1, 4, 1'b0);
`else
    check_xfer("phy_to_blk2", 2, 0, 1, 1'b1);
`endif

    run_xfer(1'b1, 4'd2, 1'b1, 1'b1, 16'd0, 300, -1, 0, -1);
    check_xfer("limit0", 2, 1, 2, 1'b0);

    run_xfer(1'b0, 4'd2, 1'b1, 1'b0, 16'd20, 150, -1, 0, -1);
    check_xfer("wd_off", 2, 1, 2, 1'b0);

    lim_b = $urandom_range(5, 40);
    run_xfer(1'b1, 4'd1, 1'b0, 1'b1, 16'(lim_b), 100000, -1, 1, -1);
    check_xfer("wd_edge", 0, 0, 0, 1'b1);
    check_eq("wd_edge_busy", 64'(g_busy), 64'(lim_b + 2));

    for (int i = 0; i < 20; i++) begin
      d  = 1'($urandom_range(0, 1));
      m  = 1'($urandom_range(0, 1));
      te = 1'($urandom_range(0, 1));
      c  = BC_W'($urandom_range(0, 15));
      l  = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(60, 300));
      nb = exp_blocks(c, m);
      run_xfer(d, c, m, te, l, $urandom_range(0, 20), -1, 0, -1);
      check_xfer($sformatf("rand%0d", i), nb, 1, nb, 1'b0);
      check_eq($sformatf("rand%0d_dir", i), 64'(g_dir_ok), 64'd1);
      check_eq($sformatf("rand%0d_latch", i),
               64'({phy_if.blocks_DATA_Phy, phy_if.timeout_Reg_DATA_Phy,
                    phy_if.writeRead_DATA_Phy, phy_if.multiple_DATA_Phy}),
               64'({c, l, d, m}));
    end

    run_xfer(1'b0, 4'd8, 1'b1, 1'b1, 16'd100, 0, -1, 0, 3);
    check_eq("rst_mid_hit", 64'(g_reset_hit), 64'd1);
    check_eq("rst_mid_strobes", 64'(g_strobes), 64'd4);
    @(negedge clk);
    check_eq("rst_mid_vec", out_vec(), RESET_VEC);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_mid_no_pulse", 64'(xfer_done), 64'd0);

    run_xfer(1'b1, 4'd3, 1'b1, 1'b1, 16'd100, 0, -1, 0, -1);
    check_xfer("after_rst", 3, 1, 3, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
